switch_debouncer: RTL
=====================

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

Interface
REQ-001 Parameter CNT_MAX, default 500000; number of consecutive stable synchronized cycles needed before a debounced output changes (10 ms at 50 MHz); legal range 2..2^24.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 s1_raw, s2_raw, s3_raw, s4_raw  input  1 each  asynchronous, bouncing slide-switch levels.
REQ-005 boton_raw  input  1  asynchronous, bouncing push-button level (1 = pressed).
REQ-006 s1, s2, s3, s4  output  1 each  debounced switch levels; these feed the switch inputs of the LED decoder stage.
REQ-007 boton  output  1  debounced button level; this feeds the decoder's button input.
REQ-008 boton_press  output  1  one-cycle pulse on the debounced button press; its behaviour is set by REQ-021.

Function
REQ-009 Each of the five channels SHALL be independent and identical: a 2-flop synchronizer, a counter of width clog2(CNT_MAX), and a debounced output register.
REQ-010 Synchronizer: sync1 <= raw and sync2 <= sync1 on every edge; only sync2 SHALL be used by downstream logic.
REQ-011 Per-channel states: STABLE (sync2 == out, counter = 0) and PENDING (sync2 != out, counter counting).
REQ-012 In STABLE, counter SHALL hold 0; if sync2 != out, the channel SHALL enter PENDING and set counter to 1 on that edge.
REQ-013 In PENDING, if sync2 == out, the channel SHALL clear counter to 0 and return to STABLE; out is unchanged (glitch rejected).
REQ-014 In PENDING, if sync2 != out and counter == CNT_MAX-1, then on that edge out <= sync2, counter <= 0, and the channel returns to STABLE.
REQ-015 In PENDING, if sync2 != out and counter < CNT_MAX-1, counter SHALL increment by 1; the counter SHALL never exceed CNT_MAX-1 and SHALL never wrap.
REQ-016 Latency: a clean raw transition first sampled at edge k SHALL appear on the output after edge k+CNT_MAX+1, i.e. CNT_MAX+2 edges including edge k.
REQ-017 Any return to the old level for at least one synchronized cycle SHALL restart the full CNT_MAX count.
REQ-018 Simultaneous transitions on several channels SHALL be handled independently with identical latency; there is no priority between channels.
REQ-019 Outputs SHALL be driven directly from registers, with no combinational path from any raw input to any output.

Reset
REQ-020 While rst=1 at a rising edge, all sync flops, counters, s1..s4, boton and boton_press SHALL become 0. Reset asserted mid-count SHALL abort the count. After rst deasserts, a raw input held at 1 SHALL reach its output after CNT_MAX+2 edges.

Configuration
REQ-021 Macro BTN_EDGE_EN, when defined: boton_press SHALL be 1 for exactly the one cycle following the edge on which boton goes 0->1, and 0 otherwise; it stays 0 on release.
REQ-022 Macro BTN_EDGE_EN, when not defined: boton_press SHALL be constant 0, and no edge-detect register is built. The port SHALL remain present in both builds.

Verification (CNT_MAX=4)
REQ-023 Reset, then s1_raw 0->1 held -> s1 = 1 exactly 6 edges after the first sampling edge; s2..s4 and boton stay 0.
REQ-024 boton_raw high for 3 cycles, then low -> boton never asserts; counter returns to 0.
REQ-025 boton_raw bounces 1,0,1,0 on alternate cycles, then holds 1 -> boton = 1 six edges after the final 0->1 transition. With BTN_EDGE_EN, boton_press = 1 for one cycle only; without it, boton_press stays 0.
REQ-026 All five raw inputs rise on the same cycle -> all five outputs rise on the same edge.
REQ-027 s3_raw = 1 held; assert rst for 1 cycle when the counter is 2 -> s3 stays 0; s3 = 1 six edges after the first post-reset sampling edge.
REQ-028 s4 = 1 stable, then s4_raw 1->0 held -> s4 = 0 after 6 edges; throughout, no output ever changes on the same edge as its raw input.

Source files
------------

// File: rtl/switch_debouncer.sv
// Five-channel switch/button debouncer: 2-flop synchronizer plus a stability counter per channel.
// Define BTN_EDGE_EN to build the registered one-cycle boton_press pulse; otherwise boton_press is tied 0.

module switch_debouncer_ch #(
  parameter int CNT_MAX = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic out,
  output logic rise
);
  localparam int CW = $clog2(CNT_MAX);

  typedef enum logic {STABLE, PENDING} st_t;

  logic          sync1, sync2, out_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  st_t           st;

  // Channel is pending exactly while the synchronized level disagrees with the output
  assign st = (sync2 == out) ? STABLE : PENDING;

  always_comb begin
    cnt_nxt = '0;
    out_nxt = out;
    case (st)
      STABLE:  cnt_nxt = '0;
      PENDING: begin
        if (cnt == CW'(CNT_MAX - 1)) out_nxt = sync2;
        else                         cnt_nxt = cnt + CW'(1);
      end
    endcase
  end

  assign rise = out_nxt & ~out;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      out   <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
    end
  end
endmodule

module switch_debouncer #(
  parameter int CNT_MAX = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic s1_raw,
  input  logic s2_raw,
  input  logic s3_raw,
  input  logic s4_raw,
  input  logic boton_raw,
  output logic s1,
  output logic s2,
  output logic s3,
  output logic s4,
  output logic boton,
  output logic boton_press
);
  localparam int NUM_CH = 5;

  logic [NUM_CH-1:0] raw, deb, rise;
  logic              unused_rise;

  assign raw = {boton_raw, s4_raw, s3_raw, s2_raw, s1_raw};
  assign {boton, s4, s3, s2, s1} = deb;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      switch_debouncer_ch #(.CNT_MAX(CNT_MAX)) u_ch (
        .clk  (clk),
        .rst  (rst),
        .raw  (raw[i]),
        .out  (deb[i]),
        .rise (rise[i])
      );
    end
  endgenerate

  // Only the button's rise feeds the press pulse; switch rises are not needed
  assign unused_rise = ^rise;

`ifdef BTN_EDGE_EN
  // Registered from the channel's next-state rise, so it is high in the same cycle boton first reads 1
  always_ff @(posedge clk) begin
    if (rst) boton_press <= 1'b0;
    else     boton_press <= rise[NUM_CH-1];
  end
`else
  assign boton_press = 1'b0;
`endif
endmodule
